// File: rtl/score_display_driver.sv
// Four-digit multiplexed seven-segment score display driver.
// Two players, two BCD digits each; one digit slot is driven per refresh
// period, with leading-zero blanking on the tens digits and the decimal point
// lit on position 2 as the player separator.
// Optional macro SCORE_FLASH_EN compiles in per-player flashing of a score
// pair after it changes.
module score_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int FLASH_SCANS = 512,
  parameter int FLASH_SHIFT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // Tens positions (odd index) hide a zero; ones positions always show.
  function automatic logic lz_blank(input logic [1:0] pos, input logic [3:0] d);
    lz_blank = pos[0] && (d == 4'd0);
  endfunction

  logic [PW-1:0] presc_p0;
  logic          vld_p0;
  logic [1:0]    idx_p0;
  logic [15:0]   snap_p0;
  logic [15:0]   snap_in;
  logic          snap_load;
  logic [3:0]    cur_dig;
  logic          flash_blank;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign vld_p0    = (presc_p0 == PW'(REFRESH_DIV - 1));
  assign snap_in   = {dig3, dig2, dig1, dig0};
  assign snap_load = vld_p0 && (idx_p0 == 2'd3);

  // ---- stage p0: prescaler, scan index and snapshot ----

  // Free-running slot prescaler, wraps after REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset)       presc_p0 <= '0;
    else if (vld_p0) presc_p0 <= '0;
    else             presc_p0 <= presc_p0 + 1'b1;
  end

  // Scan index advances once per slot; inputs are captured at the end of a
  // scan so one full scan always shows one coherent score.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p0  <= 2'd0;
      snap_p0 <= '0;
    end else if (vld_p0) begin
      idx_p0 <= idx_p0 + 2'd1;
      if (snap_load) snap_p0 <= snap_in;
    end
  end

`ifdef SCORE_FLASH_EN
  localparam int FW0 = $clog2(FLASH_SCANS + 1);
  localparam int FW  = (FW0 > FLASH_SHIFT) ? FW0 : FLASH_SHIFT + 1;

  logic [FW-1:0] fl1_p0;
  logic [FW-1:0] fl2_p0;
  logic          clear_in;
  logic          chg1;
  logic          chg2;
  logic          blank1;
  logic          blank2;

  function automatic logic [FW-1:0] fl_step(input logic chg, input logic [FW-1:0] c);
    if (chg)            fl_step = FW'(FLASH_SCANS);
    else if (c != '0)   fl_step = c - 1'b1;
    else                fl_step = '0;
  endfunction

  assign clear_in = (snap_in == 16'h0000);
  assign chg1     = (snap_in[7:0]  != snap_p0[7:0]);
  assign chg2     = (snap_in[15:8] != snap_p0[15:8]);
  assign blank1   = (fl1_p0 != '0) && fl1_p0[FLASH_SHIFT];
  assign blank2   = (fl2_p0 != '0) && fl2_p0[FLASH_SHIFT];

  // Per-pair flash counters, stepped once per snapshot; a cleared board
  // cancels any flash in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      fl1_p0 <= '0;
      fl2_p0 <= '0;
    end else if (snap_load) begin
      if (clear_in) begin
        fl1_p0 <= '0;
        fl2_p0 <= '0;
      end else begin
        fl1_p0 <= fl_step(chg1, fl1_p0);
        fl2_p0 <= fl_step(chg2, fl2_p0);
      end
    end
  end

  assign flash_blank = idx_p0[1] ? blank2 : blank1;
`else
  assign flash_blank = 1'b0;
`endif

  // Digit/segment selection for the position being driven this slot.
  always_comb begin
    cur_dig  = snap_p0[idx_p0*4 +: 4];
    an_next  = ~(4'b0001 << idx_p0);
    dp_next  = (idx_p0 != 2'd2);
    seg_next = seg_decode(cur_dig);
    if (lz_blank(idx_p0, cur_dig) || flash_blank) seg_next = 7'b1111111;
  end

  // ---- stage p1: registered display outputs ----

  // Outputs change only on slot boundaries and are dark during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (vld_p0) begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// Scoreboard bench for score_display_driver (REFRESH_DIV=4, FLASH_SCANS=8,
// FLASH_SHIFT=2). Flash expectations apply when SCORE_FLASH_EN is defined.
module tb_score_display_driver;

  localparam int DIV   = 4;
  localparam int FS    = 8;
  localparam int SHIFT = 2;
`ifdef SCORE_FLASH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dig0 = '0, dig1 = '0, dig2 = '0, dig3 = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_vec = 0;
  int n_miss = 0;
  int n_slot = 0;

  int m_idx;
  int m_snap [4];
  int m_c1, m_c2;
  logic [11:0] exp_q [$];

  score_display_driver #(
    .REFRESH_DIV(DIV),
    .FLASH_SCANS(FS),
    .FLASH_SHIFT(SHIFT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dig0 (dig0),
    .dig1 (dig1),
    .dig2 (dig2),
    .dig3 (dig3),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_miss++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               tag, got[11:8], got[7:1], got[0], expv[11:8], expv[7:1], expv[0]);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d > 9) ? 7'b0111111 : tbl[d];
  endfunction

  function automatic bit fl_on(input int c);
    return (c != 0) && (((c >> SHIFT) & 1) == 1);
  endfunction

  function automatic int fl_next(input bit chg, input int c);
    if (chg) return FS;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    m_idx = 0;
    m_c1 = 0;
    m_c2 = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 0;
  endtask

  // Expected outputs for the slot that ends at this tick, then model update.
  function automatic logic [11:0] model_tick();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d, n [4];
    bit         c1, c2;
    d     = m_snap[m_idx];
    e_an  = 4'b1111;
    e_an[m_idx] = 1'b0;
    e_dp  = (m_idx != 2);
    e_seg = ref_seg(d);
    if ((m_idx == 1 || m_idx == 3) && d == 0) e_seg = 7'b1111111;
    if (FL && (m_idx < 2) && fl_on(m_c1)) e_seg = 7'b1111111;
    if (FL && (m_idx >= 2) && fl_on(m_c2)) e_seg = 7'b1111111;
    if (m_idx == 3) begin
      n = '{int'(dig0), int'(dig1), int'(dig2), int'(dig3)};
      c1 = (n[0] != m_snap[0]) || (n[1] != m_snap[1]);
      c2 = (n[2] != m_snap[2]) || (n[3] != m_snap[3]);
      if (n[0] == 0 && n[1] == 0 && n[2] == 0 && n[3] == 0) begin
        m_c1 = 0;
        m_c2 = 0;
      end else begin
        m_c1 = fl_next(c1, m_c1);
        m_c2 = fl_next(c2, m_c2);
      end
      m_snap = n;
    end
    m_idx = (m_idx + 1) % 4;
    return {e_an, e_seg, e_dp};
  endfunction

  task automatic step_slot(input int waits);
    logic [11:0] e;
    repeat (waits) @(posedge clk);
    exp_q.push_back(model_tick());
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("slot%0d", n_slot), {an, seg, dp}, e);
    n_slot++;
  endtask

  task automatic run_slots(input int n);
    for (int i = 0; i < n; i++) step_slot(DIV);
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("in_reset", {an, seg, dp}, 12'hFFF);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < DIV - 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pre_tick", {an, seg, dp}, 12'hFFF);
    end
    step_slot(1);
  endtask

  initial begin
    dig3 = 4'd0; dig2 = 4'd7; dig1 = 4'd1; dig0 = 4'd2;
    do_reset(3);
    run_slots(7);
    // Change dig0 mid-scan (model index is 1 here); must not tear.
    run_slots(1);
    dig0 = 4'd5;
    run_slots(8);
    // Non-BCD on position 2 shows a dash.
    dig2 = 4'd12;
    run_slots(8);
    dig2 = 4'd7;
    run_slots(8);
    // Player-1 score change: flashes for FS scans when flash is compiled in.
    dig0 = 4'd6;
    run_slots(4 * 11);
    // New change, then clear the board during the flash.
    dig1 = 4'd2;
    run_slots(4 * 5);
    dig0 = 4'd0; dig1 = 4'd0; dig2 = 4'd0; dig3 = 4'd0;
    run_slots(4 * 4);
    // Both pairs change together.
    dig0 = 4'd9; dig1 = 4'd9; dig2 = 4'd3; dig3 = 4'd4;
    run_slots(4 * 10);
    // Reset in the middle of a scan takes effect on the next edge.
    repeat (2) @(posedge clk);
    do_reset(1);
    run_slots(9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
SCORE_DISPLAY_DRIVER -- requirements
Module: score_display_driver

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; reset is sampled only on the rising clock edge.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot, legal range 2..2^20.
REQ-003 Parameter FLASH_SCANS, default 512: full scans a changed score pair flashes (used only with SCORE_FLASH_EN).
REQ-004 Parameter FLASH_SHIFT, default 6: counter bit whose value 1 blanks a flashing pair.
REQ-005 Port clk  input  1  system clock.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port dig0  input  4  player-1 ones, BCD.
REQ-008 Port dig1  input  4  player-1 tens, BCD.
REQ-009 Port dig2  input  4  player-2 ones, BCD.
REQ-010 Port dig3  input  4  player-2 tens, BCD.
REQ-011 Port an  output  4  digit enables, active-low; an[k] drives display position k.
REQ-012 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 Port dp  output  1  decimal point, active-low.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick is asserted on the cycle the count equals REFRESH_DIV-1.
REQ-015 The 2-bit scan index SHALL advance 0->1->2->3->0 on each tick only.
REQ-016 On a tick with index 3, dig0..dig3 SHALL be captured into a snapshot; display data SHALL come only from the snapshot, so input changes mid-scan never tear.
REQ-017 Position k SHALL show snapshot digit k (an[0]=dig0 ... an[3]=dig3); exactly one an bit SHALL be low at a time after the first tick.
REQ-018 an, seg and dp SHALL be registered, one cycle after index/snapshot update.
REQ-019 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Codes 10..15 SHALL display a dash, seg=0111111.
REQ-021 Leading-zero blanking: a tens digit (positions 1, 3) equal to 0 SHALL show seg=1111111; ones digits are always shown.
REQ-022 dp SHALL be 0 only while position 2 is active (player separator), else 1.

Reset
REQ-023 While reset is high: prescaler=0, index=0, snapshot=all zero, flash counters=0, an=1111, seg=1111111, dp=1.
REQ-024 Reset asserted mid-scan SHALL take effect at the next edge; the first tick after release occurs REFRESH_DIV cycles after reset deasserts.

Configuration
REQ-025 Macro SCORE_FLASH_EN SHALL compile in per-player score-change flashing.
REQ-026 With SCORE_FLASH_EN: on a snapshot where a pair ({dig1,dig0} or {dig3,dig2}) differs from the previous snapshot, that pair's counter SHALL load FLASH_SCANS.
REQ-027 With SCORE_FLASH_EN: counters decrement by 1 per snapshot, saturate at 0; while nonzero and bit FLASH_SHIFT is 1, both digits of that pair SHALL show seg=1111111 (an still scans; dp unaffected).
REQ-028 With SCORE_FLASH_EN: a snapshot where all four digits are 0 (clear) SHALL zero both counters and start no flash; simultaneous change of both pairs SHALL load both counters.
REQ-029 Without SCORE_FLASH_EN: no flash logic is synthesized and score changes display with no blanking.

Verification
REQ-030 REFRESH_DIV=4, reset 3 cycles, release -> an=1111, seg=1111111 until first tick; then an=1110 one cycle after tick.
REQ-031 Inputs dig3..dig0=0,7,1,2, run two scans -> position 0 seg=0100100, position 1 seg=1111001, position 2 seg=1111000 with dp=0, position 3 blanked.
REQ-032 Change dig0 from 2 to 5 while index=1 -> position 0 keeps showing 2 until after the next index-3 tick, then 0010010.
REQ-033 dig2=12 -> position 2 seg=0111111.
REQ-034 SCORE_FLASH_EN, FLASH_SCANS=8, FLASH_SHIFT=2, dig0 1->2 -> player-1 pair blanked on scans where counter bit 2 is 1, normal after 8 scans; player-2 pair never blanked.
REQ-035 SCORE_FLASH_EN, active flash, drive all digits 0 -> counters zero on that snapshot, no blanking on following scans.
